// File: rtl/dp_ctrl_pkg.sv
// Shared encodings for the Data_Path control unit: FSM states, opcodes,
// ALU selects and RF write-source selects.
package dp_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_LOAD_A = 4'd3,
        ST_LOAD_B = 4'd4,
        ST_STORE  = 4'd5,
        ST_ALU    = 4'd6,
        ST_HALT   = 4'd7
    } state_e;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    localparam logic SEL_MEM = 1'b0;
    localparam logic SEL_ALU = 1'b1;

    // Illegal opcodes fall through to FETCH, i.e. behave as NOOP.
    function automatic state_e decode_next(input logic [3:0] op);
        case (op)
            OP_STORE: decode_next = ST_STORE;
            OP_LOAD:  decode_next = ST_LOAD_A;
            OP_ADD:   decode_next = ST_ALU;
            OP_SUB:   decode_next = ST_ALU;
            OP_HALT:  decode_next = ST_HALT;
            default:  decode_next = ST_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/dp_ctrl_decode.sv
// Combinational output decode: current state plus IR fields drive every
// Data_Path control line; anything a state does not use stays at 0.
module dp_ctrl_decode
    import dp_ctrl_pkg::*;
#(
    parameter int PC_W = 7
) (
    input  state_e            i_state,
    input  logic [15:0]       i_ir,
    input  logic [PC_W-1:0]   i_pc,
    output logic [PC_W-1:0]   o_pc_addr,
    output logic              o_instr_req,
    output logic [7:0]        o_d_addr,
    output logic              o_d_wr,
    output logic              o_mux_sel,
    output logic [2:0]        o_alu_s,
    output logic [3:0]        o_rf_a_addr,
    output logic [3:0]        o_rf_b_addr,
    output logic              o_rf_wen,
    output logic [3:0]        o_rf_waddr,
    output logic              o_halted
);

    logic [3:0] w_op;
    logic [3:0] w_ra;
    logic [3:0] w_rb;
    logic [3:0] w_rd;
    logic [7:0] w_addr;

    assign w_op   = i_ir[15:12];
    assign w_ra   = i_ir[11:8];
    assign w_rb   = i_ir[7:4];
    assign w_rd   = i_ir[3:0];
    assign w_addr = i_ir[7:0];

    always_comb begin
        o_pc_addr   = '0;
        o_instr_req = 1'b0;
        o_d_addr    = '0;
        o_d_wr      = 1'b0;
        o_mux_sel   = SEL_MEM;
        o_alu_s     = ALU_PASS;
        o_rf_a_addr = '0;
        o_rf_b_addr = '0;
        o_rf_wen    = 1'b0;
        o_rf_waddr  = '0;
        o_halted    = 1'b0;
        case (i_state)
            ST_FETCH: begin
                o_instr_req = 1'b1;
                o_pc_addr   = i_pc;
            end
            ST_STORE: begin
                o_d_addr    = w_addr;
                o_rf_a_addr = w_ra;
                o_d_wr      = 1'b1;
            end
            // LOAD_A only presents the address; the memory's q arrives next cycle.
            ST_LOAD_A: begin
                o_d_addr = w_addr;
            end
            ST_LOAD_B: begin
                o_d_addr   = w_addr;
                o_mux_sel  = SEL_MEM;
                o_rf_wen   = 1'b1;
                o_rf_waddr = w_ra;
            end
            ST_ALU: begin
                o_rf_a_addr = w_ra;
                o_rf_b_addr = w_rb;
                o_alu_s     = (w_op == OP_SUB) ? ALU_SUB : ALU_ADD;
                o_mux_sel   = SEL_ALU;
                o_rf_wen    = 1'b1;
                o_rf_waddr  = w_rd;
            end
            ST_HALT: begin
                o_halted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dp_controller.sv
// Multi-cycle controller for Data_Path: FSM, PC and IR registers, with the
// output decode delegated to dp_ctrl_decode.
module dp_controller
    import dp_ctrl_pkg::*;
#(
    parameter int PC_W = 7
) (
    input  logic              Clk,
    input  logic              Rst,
    output logic [PC_W-1:0]   PC_Addr,
    output logic              Instr_Req,
    input  logic              Instr_Valid,
    input  logic [15:0]       Instr,
    output logic [7:0]        D_addr,
    output logic              D_wr,
    output logic              MuxSel,
    output logic [2:0]        ALU_s,
    output logic [3:0]        RF_A_Addr,
    output logic [3:0]        RF_B_Addr,
    output logic              RFWen,
    output logic [3:0]        RFWAddr,
    output logic              Halted,
    output logic [3:0]        State
);

    state_e            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [15:0]       r_ir;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= ST_INIT;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            case (r_state)
                ST_INIT:   r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (Instr_Valid) begin
                        r_ir    <= Instr;
                        r_pc    <= r_pc + 1'b1;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: r_state <= decode_next(r_ir[15:12]);
                ST_LOAD_A: r_state <= ST_LOAD_B;
                ST_LOAD_B: r_state <= ST_FETCH;
                ST_STORE:  r_state <= ST_FETCH;
                ST_ALU:    r_state <= ST_FETCH;
                ST_HALT:   r_state <= ST_HALT;
                default:   r_state <= ST_INIT;
            endcase
        end
    end

    assign State = r_state;

    dp_ctrl_decode #(.PC_W(PC_W)) u_decode (
        .i_state     (r_state),
        .i_ir        (r_ir),
        .i_pc        (r_pc),
        .o_pc_addr   (PC_Addr),
        .o_instr_req (Instr_Req),
        .o_d_addr    (D_addr),
        .o_d_wr      (D_wr),
        .o_mux_sel   (MuxSel),
        .o_alu_s     (ALU_s),
        .o_rf_a_addr (RF_A_Addr),
        .o_rf_b_addr (RF_B_Addr),
        .o_rf_wen    (RFWen),
        .o_rf_waddr  (RFWAddr),
        .o_halted    (Halted)
    );

endmodule
